axis_zmod_adc_avg: RTL
======================

// Module: axis_zmod_adc_avg
// PURPOSE
//  Dual-channel Zmod ADC front end with boxcar decimation.
//  - Captures the DDR ADC bus with per-bit IDDR (SAME_EDGE_PIPELINED): Q1 is channel A, Q2 is channel B.
//  - Accumulates cfg_ratio samples per channel, scales each sum by an arithmetic right shift, saturates it,
//    and emits one packed {B,A} word per decimation period.
//  - Sits between the ADC pins and the DMA/FIFO chain, and replaces free-running tvalid=1 capture where the
//    downstream side can apply backpressure.
// PARAMETERS
//  ADC_DATA_WIDTH    14  ADC sample width, two's complement.
//  AXIS_TDATA_WIDTH  32  output word width; each channel gets AXIS_TDATA_WIDTH/2 bits (OW).
//  CNTR_WIDTH        16  width of cfg_ratio and the decimation counter.
//  SHIFT_WIDTH        5  width of cfg_shift.
// PORTS
//  aclk           in   1                 ADC clock (DDR: both edges carry data).
//  aresetn        in   1                 Asynchronous, active-low reset.
//  adc_data       in   ADC_DATA_WIDTH    DDR ADC bus from pins.
//  cfg_ratio      in   CNTR_WIDTH        Samples per output, per channel; 0 is treated as 1.
//  cfg_shift      in   SHIFT_WIDTH       Arithmetic right shift applied to each sum.
//  m_axis_tready  in   1                 Downstream ready.
//  m_axis_tvalid  out  1                 Output word valid.
//  m_axis_tdata   out  AXIS_TDATA_WIDTH  {chB[OW-1:0], chA[OW-1:0]}.
//  sts_overrun    out  1                 Sticky flag: a decimated result was dropped.
// BEHAVIOUR
//  - Reset (async assert, sync release): accumulators, counter, m_axis_tvalid, m_axis_tdata and sts_overrun
//    are all cleared to 0. IDDR R/S are tied to 0; the IDDRs are not reset.
//  - Capture: IDDR Q1/Q2 go into sample registers a_q/b_q every cycle, sign-extended to accumulator width
//    AW = ADC_DATA_WIDTH + CNTR_WIDTH.
//  - Counter cnt counts 0 .. R-1, with R = max(cfg_ratio, 1). cfg_ratio and cfg_shift are sampled in the
//    dump cycle (cnt == R-1). A ratio change therefore takes effect on the next period and never truncates
//    the current one. If cnt >= R after a ratio decrease, the cycle is treated as a dump.
//  - Non-dump cycle: acc_x <= acc_x + x_q; cnt <= cnt + 1.
//  - Dump cycle: res_x = (acc_x + x_q) >>> cfg_shift; acc_x <= 0; cnt <= 0.
//  - Saturation: res_x is clamped to [-2^(OW-1), 2^(OW-1)-1]. No wrap-around is allowed at any ratio/shift.
//    AW bits guarantee the sum itself cannot overflow.
//  - Output register (one entry) when a dump result is ready:
//    - If !m_axis_tvalid, or m_axis_tvalid && m_axis_tready in the same cycle: load tdata and set tvalid.
//      This lets a simultaneous accept and new result sustain a 1-per-R rate.
//    - Otherwise: the result is dropped, sts_overrun <= 1, and the held tdata stays unchanged.
//  - Without a new result, tvalid clears on tvalid && tready.
//  - tdata is stable while tvalid && !tready (AXIS rule).
//  - Latency: sample present on the IDDR Q outputs at edge t appears in tdata, tvalid=1, at edge t+2 when
//    R=1. Generally, output follows the last sample of a period by 2 edges.
//  - R=1, shift=0: passthrough of sign-extended samples. Output is continuous when tready=1.
//  - Reset mid-period: the partial sum is discarded. The first output after release covers exactly R full
//    samples, starting from the first a_q captured after release.
//  - sts_overrun is cleared only by aresetn.
// TESTING
//  1. R=1, shift=0, tready=1, ramp on A from 0, constant -5 on B
//     -> tdata[15:0] = ramp delayed 2 cycles, tdata[31:16] = 16'hFFFB, tvalid held at 1.
//  2. R=4, shift=2, A=100, B=-100 constant
//     -> one word every 4 cycles, A=100, B=-100, tvalid high for 1 cycle each (tready=1).
//  3. R=65535, shift=0, A=8191 full-scale
//     -> A saturates at 32767. Repeat with A=-8192 -> -32768.
//  4. R=2, hold tready=0 for 10 cycles
//     -> first word held unchanged, sts_overrun=1 after the second dump. Releasing tready delivers the held
//        word, then normal flow resumes.
//  5. R=8 running; change cfg_ratio to 2 mid-period; separately assert aresetn=0 for 1 cycle
//     -> current period completes with 8 samples, then 2-sample periods follow.
//     -> on reset, all outputs go to 0 immediately and the next word is the sum of 2 fresh samples.

Source files
------------

// File: rtl/axis_zmod_adc_avg.sv
// Dual-channel Zmod ADC front end: DDR capture, boxcar decimation with shift scaling and
// saturation, and a single-entry AXI-Stream output register that tolerates backpressure.
module axis_zmod_adc_avg #(
  parameter int ADC_DATA_WIDTH   = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16,
  parameter int SHIFT_WIDTH      = 5
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [ADC_DATA_WIDTH-1:0]   adc_data,
  input  logic [CNTR_WIDTH-1:0]       cfg_ratio,
  input  logic [SHIFT_WIDTH-1:0]      cfg_shift,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        sts_overrun
);
  localparam int OW = AXIS_TDATA_WIDTH / 2;
  localparam int AW = ADC_DATA_WIDTH + CNTR_WIDTH;

  function automatic logic signed [OW-1:0] sat(input logic signed [AW-1:0] v);
    if ((&v[AW-1:OW-1]) || !(|v[AW-1:OW-1])) return v[OW-1:0];
    else if (v[AW-1])                          return {1'b1, {(OW-1){1'b0}}};
    else                                       return {1'b0, {(OW-1){1'b1}}};
  endfunction

  // p0/p1: IDDR in SAME_EDGE_PIPELINED mode, not reset
  logic [ADC_DATA_WIDTH-1:0] rise_p0, fall_p0, q1_p1, q2_p1;

  always_ff @(posedge aclk) rise_p0 <= adc_data;
  always_ff @(negedge aclk) fall_p0 <= adc_data;

  always_ff @(posedge aclk) begin
    q1_p1 <= rise_p0;
    q2_p1 <= fall_p0;
  end

  // p2: sample registers; vld_p2 marks samples captured after reset release
  logic signed [ADC_DATA_WIDTH-1:0] a_q_p2, b_q_p2;
  logic                             vld_p2;

  always_ff @(posedge aclk) begin
    a_q_p2 <= q1_p1;
    b_q_p2 <= q2_p1;
  end

  logic signed [AW-1:0]   acc_a, acc_b, sum_a, sum_b, res_a, res_b;
  logic [CNTR_WIDTH-1:0]  cnt, ratio_r, ratio_cfg, ratio_eff;
  logic                   cfg_ld, dump;

  // cfg_ld selects the live ratio for the very first period after reset
  always_comb begin
    ratio_cfg = (cfg_ratio == '0) ? CNTR_WIDTH'(1) : cfg_ratio;
    ratio_eff = cfg_ld ? ratio_cfg : ratio_r;
    sum_a     = acc_a + $signed({{(AW-ADC_DATA_WIDTH){a_q_p2[ADC_DATA_WIDTH-1]}}, a_q_p2});
    sum_b     = acc_b + $signed({{(AW-ADC_DATA_WIDTH){b_q_p2[ADC_DATA_WIDTH-1]}}, b_q_p2});
    res_a     = sum_a >>> cfg_shift;
    res_b     = sum_b >>> cfg_shift;
    dump      = vld_p2 && (cnt >= ratio_eff - CNTR_WIDTH'(1));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p2  <= 1'b0;
      cfg_ld  <= 1'b1;
      ratio_r <= CNTR_WIDTH'(1);
      cnt     <= '0;
      acc_a   <= '0;
      acc_b   <= '0;
    end else begin
      vld_p2 <= 1'b1;
      if (vld_p2) begin
        cfg_ld <= 1'b0;
        if (cfg_ld || dump) ratio_r <= ratio_cfg;
        if (dump) begin
          acc_a <= '0;
          acc_b <= '0;
          cnt   <= '0;
        end else begin
          acc_a <= sum_a;
          acc_b <= sum_b;
          cnt   <= cnt + CNTR_WIDTH'(1);
        end
      end
    end
  end

  // p3: output register; a result arriving while the held word is stalled is dropped
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      sts_overrun   <= 1'b0;
    end else if (dump) begin
      if (!m_axis_tvalid || m_axis_tready) begin
        m_axis_tdata  <= {sat(res_b), sat(res_a)};
        m_axis_tvalid <= 1'b1;
      end else begin
        sts_overrun <= 1'b1;
      end
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
